// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// processor-side holding register with valid / overrun / framing-error status.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_rx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_sh;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_s_d;

    logic w_fall;
    logic w_half;
    logic w_full;

    assign w_fall = r_rx_s_d & ~r_rx_s;
    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    // Synchronizer and edge-detect history reset to the idle line level so
    // reset release never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value,
            // which is what turns these three lines into a shift chain.
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sh        <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_busy   <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            if (i_rx_ack) begin
                o_rx_valid <= 1'b0;
                o_overrun  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state   <= S_START;
                        o_rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_half) begin
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_cnt     <= '0;
                            o_rx_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_full) begin
                        r_sh  <= {r_rx_s, r_sh[7:1]};
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_full) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        o_rx_busy <= 1'b0;
                        if (r_rx_s) begin
                            // An ack in the acceptance cycle frees the holding
                            // register, so the new byte is taken instead of overrun;
                            // this later assignment overrides the ack clear of valid.
                            if (!o_rx_valid || i_rx_ack) begin
                                o_rx_data  <= r_sh;
                                o_rx_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    o_rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the on-chip UART peripheral. It takes the asynchronous serial input, recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit, no parity) by mid-bit sampling, and presents each received byte to the processor-side register interface. It pairs with the UART transmitter and uses the same bit-period parameter.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per bit period (100 MHz / 115200). Legal range is 4 to 65535. Must be even.
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- rx  input  1  serial line. Asynchronous to clk. Idle level is 1.
- rx_ack  input  1  consumer acknowledge. Clears rx_valid and overrun.
- rx_data  output  8  last correctly received byte. Held until the next good frame is accepted.
- rx_valid  output  1  level: an unread byte is present in rx_data.
- rx_busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse when the sampled stop bit is 0.
- overrun  output  1  sticky flag: a good frame completed while rx_valid was already 1.

## Operation
- rx passes through a 2-flop synchronizer to produce rx_s. Both synchronizer flops reset to 1.
- Start detection uses the previous synchronized value rx_s_d. A falling edge is rx_s_d = 1 and rx_s = 0.
- Bit counter cnt is 16 bits wide. Bit index idx is 3 bits wide. Shift register sh is 8 bits wide.
- FSM states:
  - IDLE: cnt = 0. On a falling edge, go to START.
  - START: cnt increments. When cnt = CLKS_PER_BIT/2 - 1:
    - If rx_s = 0: go to DATA, with cnt = 0 and idx = 0.
    - Otherwise it was a glitch: go to IDLE without setting any flag.
  - DATA: cnt increments. When cnt = CLKS_PER_BIT - 1:
    - Shift rx_s into sh[7], shifting right, so LSB-first data ends up correctly ordered. Clear cnt.
    - If idx = 7, go to STOP. Otherwise increment idx.
  - STOP: when cnt = CLKS_PER_BIT - 1, sample rx_s, then go to IDLE:
    - rx_s = 1 and rx_valid = 0: rx_data <= sh, rx_valid <= 1.
    - rx_s = 1 and rx_valid = 1: rx_data is unchanged (the new byte is discarded) and overrun <= 1.
    - rx_s = 0: frame_err pulses for 1 cycle. rx_data, rx_valid and overrun are unchanged.
- After a break (stop bit = 0) the FSM sits in IDLE. No new frame starts until rx_s returns to 1 and then falls again.
- rx_ack:
  - rx_ack = 1 clears rx_valid and overrun on the next edge.
  - If rx_ack arrives in the same cycle as a good-stop acceptance, acceptance wins: rx_data is loaded, rx_valid = 1 and overrun = 0.
  - rx_ack while rx_valid = 0 has no effect.
- Reset values: state is IDLE, cnt = 0, idx = 0, sh = 0, rx_data = 0, rx_valid = 0, rx_busy = 0, frame_err = 0, overrun = 0.
- Reset asserted mid-frame aborts the frame immediately. No flag is raised.

## Timing
- The synchronizer adds 2 cycles of latency. The falling edge is seen 3 cycles after rx falls: 2 synchronizer stages plus the rx_s_d compare.
- Each data bit is sampled at the centre of its bit period: CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after start detection, for k = 1..8. The stop bit is sampled at k = 9.
- rx_valid rises on the edge following the stop-bit sample. That is nominally 9.5·CLKS_PER_BIT + 3 cycles after the rx falling edge.
- rx_busy:
  - Goes high on the cycle after the falling edge is detected.
  - Goes low on the same edge that sets rx_valid or pulses frame_err.
- Back-to-back frames are supported. The FSM returns to IDLE half a bit into the stop bit, so the next start edge is caught.
- Tolerated baud mismatch is about ±4% across the frame.

## Test plan
Run with CLKS_PER_BIT = 16.
- Reset, then send byte 0xA5 with a good stop bit. Require rx_data = 0xA5 and rx_valid = 1 at 155 ± 1 cycles after the rx fall. frame_err and overrun stay 0.
- Send 0x3C, then 0xFF back-to-back with no idle gap, with no rx_ack between them. Require rx_data = 0x3C, rx_valid = 1 and overrun = 1. Pulse rx_ack, then require rx_valid = 0 and overrun = 0.
- Send 0x55 with stop bit 0. Require exactly one frame_err pulse, and rx_valid and rx_data unchanged. Hold rx low for 40 cycles: require no new frame. Release rx, send 0x81: require rx_data = 0x81.
- Drive a 4-cycle low glitch on an idle line. Require the FSM to return to IDLE, rx_busy to fall within 10 cycles of detection, and no flags.
- Assert rst during bit 4 of a frame. Require every output at its reset value immediately. Then send 0x0F: require it to be received correctly.
- Assert rx_ack in the exact cycle a good stop bit is accepted, with rx_valid = 1 beforehand. Require rx_valid = 1, rx_data = the new byte, and overrun = 0.
